// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tone_sequencer
//  Purpose  : Steps a programmable frequency divider through a table of
//             (frequency code, duration) entries. Each step loads one code
//             into the divider (ld/par_out), then counts divider carry-out
//             (co) pulses until that entry's duration has elapsed.
//  Ports    : clk, reset          - clock, asynchronous active-high reset
//             wr_en/wr_addr/      - table write port, honoured only in IDLE
//             wr_code/wr_dur        (wr_dur == 0 marks end of sequence)
//             start, stop, loop   - playback control (loop is a level)
//             co                  - divider carry-out pulse
//             ld, par_out         - divider load strobe and code
//             busy, step_idx,     - status: not idle, current entry,
//             done                  one-cycle normal-end pulse
//  Revision : 1.0 - initial release
// ============================================================================
module tone_sequencer #(
   parameter int DEPTH  = 16,
   parameter int AW     = 4,
   parameter int CODE_W = 5,
   parameter int DUR_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [CODE_W-1:0] wr_code,
   input  logic [DUR_W-1:0]  wr_dur,
   input  logic              start,
   input  logic              stop,
   input  logic              loop,
   input  logic              co,
   output logic              ld,
   output logic [CODE_W-1:0] par_out,
   output logic              busy,
   output logic [AW-1:0]     step_idx,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_EVAL   = 3'd1,
      S_LOAD   = 3'd2,
      S_PLAY   = 3'd3,
      S_NEXT   = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);

   state_t              r_state, w_state_nxt;
   logic [AW-1:0]       r_idx,   w_idx_nxt;
   logic [DUR_W-1:0]    r_cnt,   w_cnt_nxt;
   logic [CODE_W-1:0]   r_par,   w_par_nxt;
   logic [CODE_W-1:0]   r_code [DEPTH];
   logic [DUR_W-1:0]    r_dur  [DEPTH];
   logic [DUR_W-1:0]    w_cur_dur;
   logic [CODE_W-1:0]   w_cur_code;

   assign w_cur_dur  = r_dur[r_idx];
   assign w_cur_code = r_code[r_idx];

   // ------------------------------------------------------------------------
   // Entry table. Writes are only accepted while idle so a running sequence
   // never sees its entries change underneath it.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_code[i] <= '0;
            r_dur[i]  <= '0;
         end
      end else if (r_state == S_IDLE && wr_en) begin
         r_code[wr_addr] <= wr_code;
         r_dur[wr_addr]  <= wr_dur;
      end
   end

   // ------------------------------------------------------------------------
   // State register and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_par   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_par   <= w_par_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_par_nxt   = r_par;

      // stop overrides everything outside IDLE; step_idx is left as-is
      if (r_state != S_IDLE && stop) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && !stop) begin
                  w_state_nxt = S_EVAL;
                  w_idx_nxt   = '0;
               end
            end

            S_EVAL: begin
               if (w_cur_dur == '0) begin
                  // A zero entry past index 0 wraps when looping; at index 0
                  // it always ends so an empty table cannot spin forever.
                  if (loop && r_idx != '0) begin
                     w_idx_nxt   = '0;
                     w_state_nxt = S_EVAL;
                  end else begin
                     w_state_nxt = S_FINISH;
                  end
               end else begin
                  // par_out is captured here so it is valid during the ld cycle
                  w_par_nxt   = w_cur_code;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_LOAD;
               end
            end

            S_LOAD: begin
               // co in this cycle is deliberately ignored
               w_cnt_nxt   = '0;
               w_state_nxt = S_PLAY;
            end

            S_PLAY: begin
               if (co) begin
                  if (r_cnt == w_cur_dur - DUR_W'(1)) begin
                     w_state_nxt = S_NEXT;
                  end else begin
                     w_cnt_nxt = r_cnt + DUR_W'(1);
                  end
               end
            end

            S_NEXT: begin
               if (r_idx == c_last_idx) begin
                  if (loop) begin
                     w_idx_nxt   = '0;
                     w_state_nxt = S_EVAL;
                  end else begin
                     w_state_nxt = S_FINISH;
                  end
               end else begin
                  w_idx_nxt   = r_idx + AW'(1);
                  w_state_nxt = S_EVAL;
               end
            end

            S_FINISH: begin
               w_state_nxt = S_IDLE;
            end

            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs, all decoded from registered state
   // ------------------------------------------------------------------------
   assign ld       = (r_state == S_LOAD);
   assign done     = (r_state == S_FINISH);
   assign busy     = (r_state != S_IDLE);
   assign par_out  = r_par;
   assign step_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tone_sequencer
//  Purpose  : Directed self-checking bench for tone_sequencer. Inputs change
//             1 time unit after the rising edge; outputs are sampled there.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tone_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [4:0] wr_code;
   logic [7:0] wr_dur;
   logic       start, stop, loop, co;
   logic       ld, busy, done;
   logic [4:0] par_out;
   logic [3:0] step_idx;

   int n_assert = 0;
   int n_fail   = 0;
   int ld_cnt   = 0;
   int done_cnt = 0;
   int ld0, d0;

   tone_sequencer dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_code  (wr_code),
      .wr_dur   (wr_dur),
      .start    (start),
      .stop     (stop),
      .loop     (loop),
      .co       (co),
      .ld       (ld),
      .par_out  (par_out),
      .busy     (busy),
      .step_idx (step_idx),
      .done     (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ld)   ld_cnt   <= ld_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write_entry(input int addr, input int code, input int dur);
      wr_en   = 1'b1;
      wr_addr = 4'(addr);
      wr_code = 5'(code);
      wr_dur  = 8'(dur);
      tick();
      wr_en   = 1'b0;
   endtask

   // Divider model: one co pulse every 'period' cycles; returns in the cycle
   // after the pulse was sampled.
   task automatic co_pulse(input int period);
      repeat (period - 1) tick();
      co = 1'b1;
      tick();
      co = 1'b0;
   endtask

   task automatic wait_ld(input string tag);
      int n = 0;
      while (ld !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      check(tag, {31'd0, ld}, 32'd1);
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_code = '0; wr_dur = '0;
      start = 1'b0; stop = 1'b0; loop = 1'b0; co = 1'b0;
      tick(); tick();
      check("rst_ld",   {31'd0, ld},   32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_idx",  {28'd0, step_idx}, 32'd0);
      check("rst_par",  {27'd0, par_out},  32'd0);
      reset = 1'b0;
      tick();

      // ---- reset in the middle of PLAY ----
      write_entry(0, 28, 3);
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick(); tick();
      check("t1_par_play", {27'd0, par_out}, 32'd28);
      check("t1_busy_play", {31'd0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("t1_rst_ld",   {31'd0, ld},   32'd0);
      check("t1_rst_busy", {31'd0, busy}, 32'd0);
      check("t1_rst_idx",  {28'd0, step_idx}, 32'd0);
      check("t1_rst_par",  {27'd0, par_out},  32'd0);
      tick(); reset = 1'b0; tick();
      ld0 = ld_cnt; d0 = done_cnt;
      start = 1'b1; tick(); start = 1'b0;
      check("t1_eval_done", {31'd0, done}, 32'd0);
      tick();
      check("t1_done", {31'd0, done}, 32'd1);
      check("t1_no_ld", {31'd0, ld}, 32'd0);
      tick();
      check("t1_idle_busy", {31'd0, busy}, 32'd0);
      check("t1_ld_count", ld_cnt - ld0, 32'd0);
      check("t1_done_count", done_cnt - d0, 32'd1);

      // ---- three-entry sequence, loop = 0 ----
      write_entry(0, 28, 3);
      write_entry(1, 16, 2);
      write_entry(2, 5, 0);
      ld0 = ld_cnt; d0 = done_cnt;
      start = 1'b1; tick(); start = 1'b0;
      check("t2_eval_busy", {31'd0, busy}, 32'd1);
      check("t2_eval_ld",   {31'd0, ld},   32'd0);
      tick();
      check("t2_ld0",  {31'd0, ld}, 32'd1);
      check("t2_par0", {27'd0, par_out}, 32'd28);
      co_pulse(64);
      check("t2_co1_idx", {28'd0, step_idx}, 32'd0);
      check("t2_co1_ld",  {31'd0, ld}, 32'd0);
      co_pulse(64);
      check("t2_co2_busy", {31'd0, busy}, 32'd1);
      check("t2_co2_idx",  {28'd0, step_idx}, 32'd0);
      co_pulse(64);
      check("t2_c1_ld", {31'd0, ld}, 32'd0);
      tick();
      check("t2_c2_ld", {31'd0, ld}, 32'd0);
      tick();
      check("t2_ld1",  {31'd0, ld}, 32'd1);
      check("t2_par1", {27'd0, par_out}, 32'd16);
      check("t2_idx1", {28'd0, step_idx}, 32'd1);
      co_pulse(256);
      check("t2_s1co1_idx", {28'd0, step_idx}, 32'd1);
      check("t2_s1co1_done", {31'd0, done}, 32'd0);
      co_pulse(256);
      check("t2_fin_c1", {31'd0, done}, 32'd0);
      tick();
      check("t2_fin_c2", {31'd0, done}, 32'd0);
      tick();
      check("t2_done", {31'd0, done}, 32'd1);
      check("t2_done_idx", {28'd0, step_idx}, 32'd2);
      check("t2_done_par", {27'd0, par_out}, 32'd16);
      tick();
      check("t2_idle_busy", {31'd0, busy}, 32'd0);
      check("t2_idle_done", {31'd0, done}, 32'd0);
      check("t2_ld_count",   ld_cnt - ld0,   32'd2);
      check("t2_done_count", done_cnt - d0,  32'd1);

      // ---- same table, loop = 1 ----
      loop = 1'b1;
      d0 = done_cnt;
      start = 1'b1; tick(); start = 1'b0;
      tick();
      check("t3_ld0",  {31'd0, ld}, 32'd1);
      check("t3_par0", {27'd0, par_out}, 32'd28);
      co_pulse(64); co_pulse(64); co_pulse(64);
      tick(); tick();
      check("t3_ld1",  {31'd0, ld}, 32'd1);
      check("t3_par1", {27'd0, par_out}, 32'd16);
      co_pulse(256); co_pulse(256);
      wait_ld("t3_wrap_ld");
      check("t3_wrap_par", {27'd0, par_out}, 32'd28);
      check("t3_wrap_idx", {28'd0, step_idx}, 32'd0);
      check("t3_no_done", done_cnt - d0, 32'd0);
      stop = 1'b1; tick(); stop = 1'b0;
      check("t3_stop_busy", {31'd0, busy}, 32'd0);
      check("t3_stop_done", {31'd0, done}, 32'd0);
      check("t3_stop_idx",  {28'd0, step_idx}, 32'd0);
      tick();
      check("t3_stop_done_count", done_cnt - d0, 32'd0);
      loop = 1'b0;

      // ---- all sixteen entries, dur = 1 ----
      for (int k = 0; k < 16; k++) write_entry(k, k, 1);
      ld0 = ld_cnt; d0 = done_cnt;
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         wait_ld("t4_ld");
         check("t4_par", {27'd0, par_out}, 32'(k));
         check("t4_idx", {28'd0, step_idx}, 32'(k));
         tick();
         co = 1'b1; tick(); co = 1'b0;
      end
      tick();
      check("t4_done", {31'd0, done}, 32'd1);
      check("t4_done_idx", {28'd0, step_idx}, 32'd15);
      tick();
      check("t4_idle_busy", {31'd0, busy}, 32'd0);
      check("t4_ld_count", ld_cnt - ld0, 32'd16);
      check("t4_done_count", done_cnt - d0, 32'd1);

      loop = 1'b1;
      d0 = done_cnt;
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         wait_ld("t4l_ld");
         check("t4l_idx", {28'd0, step_idx}, 32'(k));
         tick();
         co = 1'b1; tick(); co = 1'b0;
      end
      wait_ld("t4l_wrap_ld");
      check("t4l_wrap_par", {27'd0, par_out}, 32'd0);
      check("t4l_wrap_idx", {28'd0, step_idx}, 32'd0);
      check("t4l_no_done", done_cnt - d0, 32'd0);
      stop = 1'b1; tick(); stop = 1'b0;
      loop = 1'b0;

      // ---- writes while busy are ignored ----
      start = 1'b1; tick(); start = 1'b0;
      wr_en = 1'b1; wr_addr = 4'd0; wr_code = 5'd31; wr_dur = 8'd9;
      tick(); tick(); tick();
      stop = 1'b1; wr_en = 1'b0;
      tick(); stop = 1'b0;
      check("t5_stop_busy", {31'd0, busy}, 32'd0);
      start = 1'b1; tick(); start = 1'b0;
      tick();
      check("t5_ld0",  {31'd0, ld}, 32'd1);
      check("t5_par0", {27'd0, par_out}, 32'd0);
      tick();
      co = 1'b1; tick(); co = 1'b0;
      tick(); tick();
      check("t5_ld1",  {31'd0, ld}, 32'd1);
      check("t5_idx1", {28'd0, step_idx}, 32'd1);
      check("t5_par1", {27'd0, par_out}, 32'd1);
      stop = 1'b1; tick(); stop = 1'b0;

      // start and stop together in IDLE: stay idle
      start = 1'b1; stop = 1'b1; tick();
      check("t5_ss_busy1", {31'd0, busy}, 32'd0);
      start = 1'b0; stop = 1'b0; tick();
      check("t5_ss_busy2", {31'd0, busy}, 32'd0);

      // ---- co during LOAD is not counted ----
      start = 1'b1; tick(); start = 1'b0;
      tick();
      check("t6_ld", {31'd0, ld}, 32'd1);
      co = 1'b1; tick(); co = 1'b0;
      repeat (4) tick();
      check("t6_still_busy", {31'd0, busy}, 32'd1);
      check("t6_still_idx",  {28'd0, step_idx}, 32'd0);
      check("t6_still_ld",   {31'd0, ld}, 32'd0);
      co = 1'b1; tick(); co = 1'b0;
      tick(); tick();
      check("t6_next_ld",  {31'd0, ld}, 32'd1);
      check("t6_next_idx", {28'd0, step_idx}, 32'd1);
      stop = 1'b1; tick(); stop = 1'b0;
      check("t6_stop_busy", {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Controller for the programmable frequency divider: steps through a programmable table of (frequency code, duration) entries.
- Each step loads one code into the divider through its ld/parIn interface, then counts divider carry-out (co) pulses until that entry's duration has elapsed.
- Sits between the user/keypad front end and the frequency divider. Turns a static divider into a melody/sweep generator.

Parameters:
- DEPTH, 16, number of table entries
- AW, 4, table address width (log2 DEPTH)
- CODE_W, 5, frequency code width; must match the divider parIn width
- DUR_W, 8, duration field width, in divider co pulses

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  table write strobe; honoured only in IDLE
- wr_addr  in  AW  table entry to write
- wr_code  in  CODE_W  frequency code for the entry
- wr_dur  in  DUR_W  duration in co pulses; 0 marks end of sequence
- start  in  1  begin playback from entry 0; sampled in IDLE only
- stop  in  1  abort playback
- loop  in  1  level; when 1, the end of the sequence wraps to entry 0
- co  in  1  carry-out pulse from the divider
- ld  out  1  divider load strobe, one cycle per step
- par_out  out  CODE_W  code driven to the divider parIn; registered, held stable
- busy  out  1  high in any state other than IDLE
- step_idx  out  AW  index of the current entry
- done  out  1  one-cycle pulse when a sequence ends normally

Behaviour:
- Reset (asynchronous): state IDLE; ld=0, par_out=0, busy=0, step_idx=0, done=0; co counter=0; all table entries cleared (code=0, dur=0).
- Table: DEPTH x (CODE_W+DUR_W) registers. Write is synchronous on wr_en in IDLE. Writes while busy are ignored and leave the table unchanged.
- States: IDLE, EVAL, LOAD, PLAY, NEXT, FINISH.
- IDLE: if start=1 and stop=0, go to EVAL with step_idx=0. start and stop together means stay in IDLE.
- EVAL: if dur[step_idx]==0, go to FINISH. Otherwise go to LOAD.
- LOAD (one cycle): ld=1, par_out=code[step_idx]. The co counter clears. Then go to PLAY.
- PLAY: ld=0 and par_out holds. Each co=1 increments the counter. When co=1 and counter==dur-1, go to NEXT.
- A co pulse in the LOAD cycle is not counted.
- NEXT: if step_idx==DEPTH-1, wrap to 0 when loop=1, otherwise go to FINISH. If step_idx<DEPTH-1, step_idx+1. Then go to EVAL.
- When loop=1, a dur==0 entry at index k>0 also wraps to entry 0: EVAL goes to NEXT-wrap instead of FINISH.
- A dur==0 entry at index 0 always finishes, which prevents an infinite zero loop.
- FINISH (one cycle): done=1, then IDLE. par_out keeps its last value. busy=0 once in IDLE.
- Latency: start sampled at edge t means EVAL at t+1 and ld=1 during cycle t+2.
- Step-to-step gap: the cycle after the final counted co is NEXT, then EVAL, then LOAD. The ld of step i+1 occurs 3 cycles after the terminating co of step i.
- stop=1 in any non-IDLE state: IDLE at the next edge, no done pulse, no ld, step_idx keeps its value. stop has priority over every other transition.
- start while busy is ignored.
- co is assumed to be a single-cycle pulse; the block does not check its width.
- Divider timing reference: the period per co is (2^9 - code*16) clk cycles.

Test Plan:
- Reset mid-PLAY (entry 0 = code 28, dur 3) -> ld=0, busy=0, step_idx=0, par_out=0 immediately. A subsequent start with no writes gives done at cycle t+2 and no ld.
- Write entry0={28,3}, entry1={16,2}, entry2={x,0}; start; model the divider (period 64, then 256) -> ld at t+2 with par_out=28. Second ld 3 cycles after the 3rd co, with par_out=16. done exactly once after the 2nd co of step 1; busy low on the next cycle.
- Same table with loop=1 -> after entry1 completes, ld reloads code 28 and step_idx=0. No done pulse. stop then returns to IDLE in 1 cycle with no done.
- All 16 entries dur=1, codes 0..15, loop=0 -> 16 ld pulses in order, done after entry 15. With loop=1, the sequence returns to entry 0.
- Write attempts while busy (wr_addr=0, wr_code=31, wr_dur=9) -> table unchanged, verified on the next run. Simultaneous start+stop in IDLE -> stays IDLE.
- co asserted during the LOAD cycle -> not counted; the step still requires dur co pulses within PLAY.
